ps2_seq_ctrlmod: RTL and testbench

Host-side sequencer for the PS/2 mouse link. It drives the byte-level transmit and receive engines through a fixed command script: reset, BAT check, sample rate, then enable data reporting. It handles ACK, resend and timeout, and retries each step. Once stream mode is established it asserts oEn, which hands the bus to the packet reader (3-byte decode, then display and LEDs).

---
 rtl/ps2_pkg.sv | 57 +++++
 rtl/ps2_script_rom.sv | 31 +++
 rtl/ps2_seq_ctrlmod.sv | 203 ++++++++++++++++++++
 tb/tb_ps2_seq_ctrlmod.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 host sequencer command codes, state encoding and script entry type
package ps2_pkg;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] CMD_GET_ID   = 8'hF2;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_ERR  = 8'hFC;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] ID_WHEEL     = 8'h03;

    // Rates of the wheel-mouse unlock knock: 200, 100, 80
    localparam logic [7:0] KNOCK_RATE_0 = 8'hC8;
    localparam logic [7:0] KNOCK_RATE_1 = 8'h64;
    localparam logic [7:0] KNOCK_RATE_2 = 8'h50;

    localparam int STEP_W = 4;
    // Receive-only step holding the BAT and ID bytes that follow the reset ACK
    localparam logic [STEP_W-1:0] STEP_BAT = 4'd1;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SEND     = 4'd1,
        ST_WAIT_TX  = 4'd2,
        ST_WAIT_ACK = 4'd3,
        ST_WAIT_BAT = 4'd4,
        ST_WAIT_ID  = 4'd5,
        ST_NEXT     = 4'd6,
        ST_RETRY    = 4'd7,
        ST_DONE     = 4'd8,
        ST_FAIL     = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        EXP_ACK     = 2'd0,
        EXP_ACK_BAT = 2'd1,
        EXP_ACK_ID  = 2'd2
    } expect_t;

    typedef struct packed {
        logic [7:0] data;
        expect_t    kind;
        logic       last;
    } script_entry_t;

    function automatic script_entry_t mk_entry(input logic [7:0] data, input expect_t kind,
                                               input logic last);
        script_entry_t e;
        e.data = data;
        e.kind = kind;
        e.last = last;
        return e;
    endfunction

endpackage

// File: rtl/ps2_script_rom.sv
// rtl/ps2_script_rom.sv - step index to script entry; PS2_INTELLIMOUSE_EN inserts the wheel knock
module ps2_script_rom
    import ps2_pkg::*;
#(
    parameter logic [7:0] SAMPLE_RATE = 8'd100
) (
    input  logic [STEP_W-1:0] step,
    output script_entry_t     entry
);

    always_comb begin
        entry = mk_entry(CMD_ENABLE, EXP_ACK, 1'b1);
        case (step)
            4'd0:    entry = mk_entry(CMD_RESET, EXP_ACK_BAT, 1'b0);
            4'd1:    entry = mk_entry(CMD_RESET, EXP_ACK_BAT, 1'b0);
            4'd2:    entry = mk_entry(CMD_SET_RATE, EXP_ACK, 1'b0);
            4'd3:    entry = mk_entry(SAMPLE_RATE, EXP_ACK, 1'b0);
`ifdef PS2_INTELLIMOUSE_EN
            4'd4:    entry = mk_entry(CMD_SET_RATE, EXP_ACK, 1'b0);
            4'd5:    entry = mk_entry(KNOCK_RATE_0, EXP_ACK, 1'b0);
            4'd6:    entry = mk_entry(CMD_SET_RATE, EXP_ACK, 1'b0);
            4'd7:    entry = mk_entry(KNOCK_RATE_1, EXP_ACK, 1'b0);
            4'd8:    entry = mk_entry(CMD_SET_RATE, EXP_ACK, 1'b0);
            4'd9:    entry = mk_entry(KNOCK_RATE_2, EXP_ACK, 1'b0);
            4'd10:   entry = mk_entry(CMD_GET_ID, EXP_ACK_ID, 1'b0);
`endif
            default: entry = mk_entry(CMD_ENABLE, EXP_ACK, 1'b1);
        endcase
    end

endmodule

// File: rtl/ps2_seq_ctrlmod.sv
// rtl/ps2_seq_ctrlmod.sv - PS/2 mouse init sequencer: script FSM, timeouts, retries (PS2_INTELLIMOUSE_EN: wheel detect)
module ps2_seq_ctrlmod
    import ps2_pkg::*;
#(
    parameter int         CLK_HZ         = 50_000_000,
    parameter int         ACK_TIMEOUT_MS = 20,
    parameter int         BAT_TIMEOUT_MS = 750,
    parameter int         MAX_RETRY      = 3,
    parameter logic [7:0] SAMPLE_RATE    = 8'd100
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       iStart,
    output logic       oTxReq,
    output logic [7:0] oTxData,
    input  logic       iTxDone,
    input  logic       iTxErr,
    input  logic       iRxTrig,
    input  logic [7:0] iRxData,
    output logic       oRxEn,
    output logic       oEn,
    output logic       oBusy,
    output logic       oFail,
    output logic       oWheel,
    output logic [3:0] oState
);

    localparam int ACK_LIM = CLK_HZ / 1000 * ACK_TIMEOUT_MS;
    localparam int BAT_LIM = CLK_HZ / 1000 * BAT_TIMEOUT_MS;
    localparam int ACK_CYC = (ACK_LIM < 1) ? 1 : ACK_LIM;
    localparam int BAT_CYC = (BAT_LIM < 1) ? 1 : BAT_LIM;
    localparam int T_MAX   = (ACK_CYC > BAT_CYC) ? ACK_CYC : BAT_CYC;
    localparam int TW      = $clog2(T_MAX + 1);
    localparam int RW      = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    state_t            state, state_d;
    logic [STEP_W-1:0] step, step_d;
    logic [RW-1:0]     retry, retry_d;
    logic [TW-1:0]     timer;
    logic [7:0]        tx_data;
    expect_t           cur_kind;
    logic              cur_last;
    script_entry_t     nxt_entry;
    logic              ack_to;
    logic              bat_to;

    // The ROM is addressed by the next step so the byte is ready as SEND is entered
    ps2_script_rom #(
        .SAMPLE_RATE(SAMPLE_RATE)
    ) u_rom (
        .step (step_d),
        .entry(nxt_entry)
    );

    assign ack_to = (timer >= TW'(ACK_CYC - 1));
    assign bat_to = (timer >= TW'(BAT_CYC - 1));

    always_comb begin
        state_d = state;
        step_d  = step;
        retry_d = retry;
        if (iStart) begin
            state_d = ST_SEND;
            step_d  = '0;
            retry_d = '0;
        end else begin
            case (state)
                ST_IDLE: state_d = ST_IDLE;
                ST_SEND: state_d = ST_WAIT_TX;
                ST_WAIT_TX: begin
                    if (iTxErr) begin
                        state_d = ST_RETRY;
                    end else if (iTxDone) begin
                        state_d = ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (iRxTrig) begin
                        if (iRxData == RSP_ACK) begin
                            case (cur_kind)
                                EXP_ACK_BAT: begin
                                    state_d = ST_WAIT_BAT;
                                    step_d  = STEP_BAT;
                                end
                                EXP_ACK_ID: state_d = ST_WAIT_ID;
                                default:    state_d = ST_NEXT;
                            endcase
                        end else begin
                            state_d = ST_RETRY;
                        end
                    end else if (ack_to) begin
                        state_d = ST_RETRY;
                    end
                end
                ST_WAIT_BAT: begin
                    // A failed or missing self-test can only be recovered by resetting again
                    if (iRxTrig) begin
                        if (iRxData == RSP_BAT_OK) begin
                            state_d = ST_WAIT_ID;
                        end else if (iRxData == RSP_BAT_ERR) begin
                            state_d = ST_RETRY;
                            step_d  = '0;
                        end
                    end else if (bat_to) begin
                        state_d = ST_RETRY;
                        step_d  = '0;
                    end
                end
                ST_WAIT_ID: begin
                    if (iRxTrig) begin
                        state_d = ST_NEXT;
                    end else if (ack_to) begin
                        state_d = ST_RETRY;
                        if (step == STEP_BAT) begin
                            step_d = '0;
                        end
                    end
                end
                ST_NEXT: begin
                    if (cur_last) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SEND;
                        step_d  = step + STEP_W'(1);
                        retry_d = '0;
                    end
                end
                ST_RETRY: begin
                    if (retry == RW'(MAX_RETRY)) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_SEND;
                        retry_d = retry + RW'(1);
                    end
                end
                ST_DONE: state_d = ST_DONE;
                ST_FAIL: state_d = ST_FAIL;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state    <= ST_IDLE;
            step     <= '0;
            retry    <= '0;
            timer    <= '0;
            tx_data  <= 8'h00;
            cur_kind <= EXP_ACK;
            cur_last <= 1'b0;
        end else begin
            state    <= state_d;
            step     <= step_d;
            retry    <= retry_d;
            cur_kind <= nxt_entry.kind;
            cur_last <= nxt_entry.last;
            if (state_d == ST_SEND) begin
                tx_data <= nxt_entry.data;
            end
            if (state_d != state) begin
                timer <= '0;
            end else if (timer != TW'(T_MAX)) begin
                timer <= timer + TW'(1);
            end
        end
    end

`ifdef PS2_INTELLIMOUSE_EN
    logic [7:0] dev_id;
    logic       wheel;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            dev_id <= 8'h00;
            wheel  <= 1'b0;
        end else if (iStart) begin
            wheel <= 1'b0;
        end else begin
            if (state == ST_WAIT_ID && iRxTrig) begin
                dev_id <= iRxData;
            end
            if (state == ST_NEXT && cur_kind == EXP_ACK_ID) begin
                wheel <= (dev_id == ID_WHEEL);
            end
        end
    end

    assign oWheel = wheel;
`else
    assign oWheel = 1'b0;
`endif

    assign oTxReq  = (state == ST_SEND);
    assign oTxData = tx_data;
    assign oRxEn   = (state inside {ST_WAIT_ACK, ST_WAIT_BAT, ST_WAIT_ID, ST_NEXT, ST_RETRY,
                                    ST_DONE});
    assign oEn     = (state == ST_DONE);
    assign oFail   = (state == ST_FAIL);
    assign oBusy   = !(state inside {ST_IDLE, ST_DONE, ST_FAIL});
    assign oState  = state;

endmodule

// File: tb/tb_ps2_seq_ctrlmod.sv
// tb/tb_ps2_seq_ctrlmod.sv - scoreboard bench for ps2_seq_ctrlmod (both PS2_INTELLIMOUSE_EN builds)
module tb_ps2_seq_ctrlmod;

    localparam logic [3:0] S_IDLE = 4'd0, S_WAIT_TX = 4'd2, S_WAIT_ACK = 4'd3;
    localparam logic [3:0] S_DONE = 4'd8, S_FAIL = 4'd9;
`ifdef PS2_INTELLIMOUSE_EN
    localparam logic WHEEL_EXP = 1'b1;
`else
    localparam logic WHEEL_EXP = 1'b0;
`endif

    logic       CLOCK = 1'b0, RESET = 1'b0, iStart = 1'b0;
    logic       iTxDone = 1'b0, iTxErr = 1'b0, iRxTrig = 1'b0;
    logic [7:0] iRxData = 8'h00;
    logic       oTxReq, oRxEn, oEn, oBusy, oFail, oWheel;
    logic [7:0] oTxData;
    logic [3:0] oState;

    ps2_seq_ctrlmod #(
        .CLK_HZ(1000), .ACK_TIMEOUT_MS(20), .BAT_TIMEOUT_MS(750), .MAX_RETRY(3),
        .SAMPLE_RATE(8'd100)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .iStart(iStart), .oTxReq(oTxReq), .oTxData(oTxData),
        .iTxDone(iTxDone), .iTxErr(iTxErr), .iRxTrig(iRxTrig), .iRxData(iRxData),
        .oRxEn(oRxEn), .oEn(oEn), .oBusy(oBusy), .oFail(oFail), .oWheel(oWheel), .oState(oState)
    );

    always #5 CLOCK = ~CLOCK;

    // mode: 0 done, 1 error, 2 done+error together, 3 no completion
    typedef struct {
        int             mode;
        int             n;
        logic [2:0][7:0] b;
    } act_t;

    act_t       act_q[$];
    logic [7:0] exp_q[$];
    int         f4_cyc[$];
    int         tx_cnt = 0, cyc = 0;
    int         n_checks = 0, n_err = 0;
    bit         resp_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge CLOCK) begin
        cyc = cyc + 1;
        if (RESET && oTxReq) begin
            tx_cnt = tx_cnt + 1;
            if (oTxData == 8'hF4) f4_cyc.push_back(cyc);
            if (exp_q.size() == 0) check("tx_unexpected", {24'd0, oTxData}, 32'h100);
            else check("tx_byte", {24'd0, oTxData}, {24'd0, exp_q.pop_front()});
        end
    end

    initial begin : responder
        act_t a;
        forever begin
            @(negedge CLOCK);
            if (RESET && oTxReq) begin
                resp_busy = 1'b1;
                if (act_q.size() > 0) a = act_q.pop_front();
                else begin a.mode = 0; a.n = 0; a.b = '0; end
                if (a.mode != 3) begin
                    repeat (2) @(negedge CLOCK);
                    iTxDone = (a.mode == 0 || a.mode == 2);
                    iTxErr  = (a.mode == 1 || a.mode == 2);
                    @(negedge CLOCK);
                    iTxDone = 1'b0;
                    iTxErr  = 1'b0;
                    for (int k = 0; k < a.n; k++) begin
                        @(negedge CLOCK);
                        iRxData = a.b[k];
                        iRxTrig = 1'b1;
                        @(negedge CLOCK);
                        iRxTrig = 1'b0;
                    end
                end
                resp_busy = 1'b0;
            end
        end
    end

    task automatic act(input int mode, input int n, input logic [7:0] b0 = 8'h00,
                       input logic [7:0] b1 = 8'h00, input logic [7:0] b2 = 8'h00);
        act_t a;
        a.mode = mode; a.n = n; a.b[0] = b0; a.b[1] = b1; a.b[2] = b2;
        act_q.push_back(a);
    endtask

    task automatic ex(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    task automatic step_ok(input logic [7:0] b);
        act(0, 1, 8'hFA); ex(b);
    endtask

    task automatic boot_ok();
        act(0, 3, 8'hFA, 8'hAA, 8'h00); ex(8'hFF);
    endtask

    task automatic push_knock(input logic [7:0] id);
`ifdef PS2_INTELLIMOUSE_EN
        step_ok(8'hF3); step_ok(8'hC8); step_ok(8'hF3); step_ok(8'h64);
        step_ok(8'hF3); step_ok(8'h50);
        act(0, 2, 8'hFA, id); ex(8'hF2);
`else
        if (id == 8'hFF) exp_q.push_back(8'hEE);
`endif
    endtask

    task automatic push_mid(input logic [7:0] id);
        step_ok(8'hF3); step_ok(8'h64); push_knock(id);
    endtask

    task automatic new_test();
        for (int i = 0; i < 50 && resp_busy; i++) @(negedge CLOCK);
        RESET = 1'b0; iStart = 1'b0; iTxDone = 1'b0; iTxErr = 1'b0; iRxTrig = 1'b0;
        act_q.delete(); exp_q.delete(); f4_cyc.delete(); tx_cnt = 0;
        repeat (2) @(negedge CLOCK);
        RESET = 1'b1;
        @(negedge CLOCK);
    endtask

    task automatic start();
        iStart = 1'b1;
        @(negedge CLOCK);
        iStart = 1'b0;
    endtask

    task automatic wait_end(input int budget, input string tag);
        int i;
        for (i = 0; i < budget && !(oEn || oFail); i++) @(negedge CLOCK);
        check({tag, "_in_time"}, {31'd0, (i < budget)}, 32'd1);
    endtask

    task automatic wait_tx(input int n, input int budget, input string tag);
        int i;
        for (i = 0; i < budget && tx_cnt < n; i++) @(negedge CLOCK);
        check({tag, "_tx_in_time"}, {31'd0, (i < budget)}, 32'd1);
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
        int i;
        for (i = 0; i < budget && oState != s; i++) @(negedge CLOCK);
        check({tag, "_state_in_time"}, {31'd0, (i < budget)}, 32'd1);
    endtask

    task automatic sb_empty(input string tag);
        check({tag, "_sb_empty"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        new_test();
        check("rst_txreq", {31'd0, oTxReq}, 32'd0);
        check("rst_txdata", {24'd0, oTxData}, 32'd0);
        check("rst_rxen", {31'd0, oRxEn}, 32'd0);
        check("rst_en", {31'd0, oEn}, 32'd0);
        check("rst_busy", {31'd0, oBusy}, 32'd0);
        check("rst_fail", {31'd0, oFail}, 32'd0);
        check("rst_wheel", {31'd0, oWheel}, 32'd0);
        check("rst_state", {28'd0, oState}, {28'd0, S_IDLE});

        // happy path
        new_test();
        boot_ok(); push_mid(8'h03); step_ok(8'hF4);
        start();
        check("happy_busy", {31'd0, oBusy}, 32'd1);
        wait_end(800, "happy");
        check("happy_en", {31'd0, oEn}, 32'd1);
        check("happy_fail", {31'd0, oFail}, 32'd0);
        check("happy_busy_done", {31'd0, oBusy}, 32'd0);
        check("happy_rxen", {31'd0, oRxEn}, 32'd1);
        check("happy_state", {28'd0, oState}, {28'd0, S_DONE});
        check("happy_wheel", {31'd0, oWheel}, {31'd0, WHEEL_EXP});
        sb_empty("happy");

        // resend / simultaneous done+err, retry cleared between steps
        new_test();
        boot_ok();
        act(2, 0); ex(8'hF3);
        act(0, 1, 8'hFE); ex(8'hF3);
        step_ok(8'hF3);
        for (int i = 0; i < 3; i++) begin act(0, 1, 8'hFE); ex(8'h64); end
        step_ok(8'h64);
        push_knock(8'h03); step_ok(8'hF4);
        start();
        wait_end(1200, "resend");
        check("resend_en", {31'd0, oEn}, 32'd1);
        check("resend_fail", {31'd0, oFail}, 32'd0);
        sb_empty("resend");

        // timeout exhaustion on F4
        new_test();
        boot_ok(); push_mid(8'h03);
        for (int i = 0; i < 4; i++) begin act(0, 0); ex(8'hF4); end
        start();
        wait_end(1200, "tmo");
        check("tmo_fail", {31'd0, oFail}, 32'd1);
        check("tmo_en", {31'd0, oEn}, 32'd0);
        check("tmo_rxen", {31'd0, oRxEn}, 32'd0);
        check("tmo_busy", {31'd0, oBusy}, 32'd0);
        check("tmo_state", {28'd0, oState}, {28'd0, S_FAIL});
        repeat (30) @(negedge CLOCK);
        check("tmo_f4_count", f4_cyc.size(), 32'd4);
        for (int i = 0; i + 1 < f4_cyc.size(); i++)
            check("tmo_gap_ge20", {31'd0, (f4_cyc[i+1] - f4_cyc[i] >= 20)}, 32'd1);
        sb_empty("tmo");

        // BAT failure
        new_test();
        for (int i = 0; i < 4; i++) begin act(0, 2, 8'hFA, 8'hFC); ex(8'hFF); end
        start();
        wait_end(600, "bat");
        check("bat_fail", {31'd0, oFail}, 32'd1);
        check("bat_en", {31'd0, oEn}, 32'd0);
        repeat (10) @(negedge CLOCK);
        sb_empty("bat");

        // abort mid-script, retry count must restart from zero
        new_test();
        boot_ok(); step_ok(8'hF3);
        act(0, 1, 8'hFE); ex(8'h64);
        act(0, 1, 8'hFE); ex(8'h64);
        act(0, 0); ex(8'h64);
        for (int i = 0; i < 3; i++) begin act(0, 1, 8'hFE); ex(8'hFF); end
        boot_ok(); push_mid(8'h03); step_ok(8'hF4);
        start();
        wait_tx(5, 400, "abort");
        wait_state(S_WAIT_ACK, 20, "abort");
        start();
        check("abort_req", {31'd0, oTxReq}, 32'd1);
        check("abort_data", {24'd0, oTxData}, 32'hFF);
        wait_end(1500, "abort");
        check("abort_en", {31'd0, oEn}, 32'd1);
        check("abort_fail", {31'd0, oFail}, 32'd0);
        sb_empty("abort");

        // async reset while waiting on the transmitter
        new_test();
        act(3, 0); ex(8'hFF);
        start();
        wait_state(S_WAIT_TX, 10, "arst");
        @(posedge CLOCK);
        #2 RESET = 1'b0;
        #1;
        check("arst_txreq", {31'd0, oTxReq}, 32'd0);
        check("arst_txdata", {24'd0, oTxData}, 32'd0);
        check("arst_busy", {31'd0, oBusy}, 32'd0);
        check("arst_rxen", {31'd0, oRxEn}, 32'd0);
        check("arst_state", {28'd0, oState}, {28'd0, S_IDLE});
        sb_empty("arst");

`ifdef PS2_INTELLIMOUSE_EN
        // plain mouse answers ID 00
        new_test();
        boot_ok(); push_mid(8'h00); step_ok(8'hF4);
        start();
        wait_end(800, "noid");
        check("noid_wheel", {31'd0, oWheel}, 32'd0);
        check("noid_en", {31'd0, oEn}, 32'd1);
        sb_empty("noid");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
